// File: rtl/mem_access.sv
// Memory stage of the vector pipeline: unpacks the execute buffer, serialises scalar/vector
// loads and stores over one synchronous N-bit port (one lane per cycle), then issues a writeback bundle.
module mem_access #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int BW = 17 + 2 * N * M
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inValid,
    input  logic [BW-1:0]     bufferIn,
    output logic              stall,
    output logic [N-1:0]      memAddr,
    output logic [N-1:0]      memWData,
    output logic              memWE,
    output logic              memRE,
    input  logic [N-1:0]      memRData,
    output logic              wbValid,
    output logic              wbModeSel,
    output logic              wbRegWrite,
    output logic              wbMemToReg,
    output logic [3:0]        wbRc,
    output logic [M*N-1:0]    wbAluResult,
    output logic [M*N-1:0]    wbReadData
);

    localparam int LW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

    // Field order mirrors the execute buffer from MSB down, so a plain assignment unpacks it.
    typedef struct packed {
        logic                mode_sel;
        logic [1:0]          op_type;
        logic [3:0]          op_code;
        logic [M-1:0][N-1:0] alu_result;
        logic                zero_flag;
        logic                neg_flag;
        logic                branch_flag;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic [3:0]          rc;
        logic [M-1:0][N-1:0] rd3;
    } exec_buf_t;

    state_t              state;
    exec_buf_t           dec;
    exec_buf_t           ins;
    logic [LW-1:0]       lane;
    logic [LW-1:0]       last_lane;
    logic                pending;
    logic [LW-1:0]       pend_lane;
    logic [M-1:0][N-1:0] rd_buf;
    logic [M-1:0][N-1:0] rd_merged;
    logic                complete;
    logic                from_input;
    logic                unused_fields;

    assign dec        = bufferIn;
    assign last_lane  = ins.mode_sel ? LW'(M - 1) : '0;
    assign from_input = (state == IDLE);

    // Flags and opcode travel with the instruction but nothing in this stage consumes them.
    assign unused_fields = ^{ins.op_type, ins.op_code, ins.zero_flag, ins.neg_flag, ins.branch_flag};

    assign stall    = (state != IDLE);
    assign memAddr  = ins.alu_result[0] + N'(lane);
    assign memWData = ins.rd3[lane];
    assign memWE    = en && (state == ACCESS) && ins.mem_write;
    assign memRE    = en && (state == ACCESS) && !ins.mem_write;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_merged = rd_buf;
        if (pending) rd_merged[pend_lane] = memRData;

        complete = 1'b0;
        case (state)
            IDLE:    complete = inValid && !dec.mem_write && !dec.mem_to_reg;
            ACCESS:  complete = (lane == last_lane) && ins.mem_write;
            DRAIN:   complete = 1'b1;
            default: complete = 1'b0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the small read-assembly buffer is reset too, so an aborted load never leaks data.
            state       <= IDLE;
            ins         <= '0;
            lane        <= '0;
            pending     <= 1'b0;
            pend_lane   <= '0;
            rd_buf      <= '0;
            wbValid     <= 1'b0;
            wbModeSel   <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbMemToReg  <= 1'b0;
            wbRc        <= '0;
            wbAluResult <= '0;
            wbReadData  <= '0;
        end else begin
            // Read return is tracked even while the stage is frozen; memory answers regardless.
            pending <= memRE;
            if (memRE) pend_lane <= lane;
            rd_buf <= rd_merged;

            if (en) begin
                case (state)
                    IDLE: begin
                        if (inValid) begin
                            ins  <= dec;
                            lane <= '0;
                            if (dec.mem_write || dec.mem_to_reg) begin
                                state  <= ACCESS;
                                rd_buf <= '0;
                            end
                        end
                    end
                    ACCESS: begin
                        if (lane == last_lane) begin
                            lane  <= '0;
                            state <= ins.mem_write ? IDLE : DRAIN;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                    DRAIN:   state <= IDLE;
                    default: state <= IDLE;
                endcase

                wbValid <= complete;
                if (complete) begin
                    wbModeSel   <= from_input ? dec.mode_sel   : ins.mode_sel;
                    wbRegWrite  <= from_input ? dec.reg_write  : ins.reg_write;
                    wbMemToReg  <= from_input ? dec.mem_to_reg : ins.mem_to_reg;
                    wbRc        <= from_input ? dec.rc         : ins.rc;
                    wbAluResult <= from_input ? dec.alu_result : ins.alu_result;
                    wbReadData  <= (state == DRAIN) ? rd_merged : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, scalar store, wrapping vector load,
// enable hold, back-to-back issue and asynchronous reset mid-store.
module tb_mem_access;

    localparam int N  = 24;
    localparam int M  = 6;
    localparam int BW = 17 + 2 * N * M;

    logic            clk, rst, en, inValid;
    logic [BW-1:0]   bufferIn;
    logic            stall, memWE, memRE, wbValid, wbModeSel, wbRegWrite, wbMemToReg;
    logic [N-1:0]    memAddr, memWData, memRData;
    logic [3:0]      wbRc;
    logic [M*N-1:0]  wbAluResult, wbReadData;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;
    logic [N-1:0] wr_addr[$];
    logic [N-1:0] wr_data[$];

    mem_access #(.N(N), .M(M), .BW(BW)) dut (
        .clk(clk), .rst(rst), .en(en), .inValid(inValid), .bufferIn(bufferIn),
        .stall(stall), .memAddr(memAddr), .memWData(memWData), .memWE(memWE), .memRE(memRE),
        .memRData(memRData), .wbValid(wbValid), .wbModeSel(wbModeSel), .wbRegWrite(wbRegWrite),
        .wbMemToReg(wbMemToReg), .wbRc(wbRc), .wbAluResult(wbAluResult), .wbReadData(wbReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: reads return address XOR 0x5A5A5A one cycle later; writes are logged.
    always @(posedge clk) begin
        if (memWE) begin
            we_cnt++;
            wr_addr.push_back(memAddr);
            wr_data.push_back(memWData);
        end
        if (memRE) re_cnt++;
        if (memWE && memRE) both_cnt++;
        memRData <= memRE ? (memAddr ^ 24'h5A5A5A) : '0;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [BW-1:0] mk(input logic mode, input logic mw, input logic mtr,
                                         input logic rw, input logic [3:0] rc,
                                         input logic [N-1:0] base, input logic [N*M-1:0] rd3);
        logic [BW-1:0] b;
        b = '0;
        b[304]     = mode;
        b[303:298] = 6'b10_1101;
        b[297:154] = {{(N*M-N){1'b0}}, base};
        b[153:151] = 3'b101;
        b[150]     = mw;
        b[149]     = mtr;
        b[148]     = rw;
        b[147:144] = rc;
        b[143:0]   = rd3;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; inValid = 1'b0; bufferIn = '0;
        #3;
        checks++;
        if ({stall, memWE, memRE, wbValid} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {stall, memWE, memRE, wbValid});
        end
        checks++;
        if ({wbRc, wbAluResult, wbReadData, memAddr} !== '0) begin
            errors++; $display("FAIL reset_data: wbRc=%h alu=%h rd=%h addr=%h expected all 0",
                               wbRc, wbAluResult, wbReadData, memAddr);
        end
        tick(); tick();
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        we_cnt = 0; re_cnt = 0;
        bufferIn = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 24'd540, {6{24'hABCDEF}});
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        checks++;
        if (wbValid !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL pt_valid: wbValid=%b stall=%b expected 1 0", wbValid, stall);
        end
        checks++;
        if (wbRc !== 4'd5 || wbRegWrite !== 1'b1 || wbModeSel !== 1'b0) begin
            errors++; $display("FAIL pt_ctrl: rc=%0d rw=%b mode=%b expected 5 1 0", wbRc, wbRegWrite, wbModeSel);
        end
        checks++;
        if (wbAluResult !== 144'd540) begin
            errors++; $display("FAIL pt_alu: got %h expected %h", wbAluResult, 144'd540);
        end
        checks++;
        if (wbReadData !== '0) begin
            errors++; $display("FAIL pt_rdata: got %h expected 0", wbReadData);
        end
        tick();
        checks++;
        if (wbValid !== 1'b0) begin
            errors++; $display("FAIL pt_pulse: wbValid=%b expected 0", wbValid);
        end
        checks++;
        if (we_cnt != 0 || re_cnt != 0) begin
            errors++; $display("FAIL pt_nomem: writes=%0d reads=%0d expected 0 0", we_cnt, re_cnt);
        end
    endtask

    task automatic test_scalar_store();
        wr_addr.delete(); wr_data.delete();
        bufferIn = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 24'h000100, {{5{24'h999999}}, 24'd32});
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        checks++;
        if (stall !== 1'b1 || memWE !== 1'b1 || memRE !== 1'b0) begin
            errors++; $display("FAIL st_strobe: stall=%b we=%b re=%b expected 1 1 0", stall, memWE, memRE);
        end
        checks++;
        if (memAddr !== 24'h000100 || memWData !== 24'd32) begin
            errors++; $display("FAIL st_bus: addr=%h data=%0d expected 000100 32", memAddr, memWData);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || wbValid !== 1'b1 || memWE !== 1'b0) begin
            errors++; $display("FAIL st_done: stall=%b wbValid=%b we=%b expected 0 1 0", stall, wbValid, memWE);
        end
        tick();
        checks++;
        if (wbValid !== 1'b0) begin
            errors++; $display("FAIL st_pulse: wbValid=%b expected 0", wbValid);
        end
        checks++;
        if (wr_addr.size() != 1) begin
            errors++; $display("FAIL st_count: writes=%0d expected 1", wr_addr.size());
        end else if (wr_addr[0] !== 24'h000100 || wr_data[0] !== 24'd32) begin
            errors++; $display("FAIL st_log: addr=%h data=%0d expected 000100 32", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_vector_load_wrap();
        logic [N-1:0] seen[$];
        logic [N-1:0] base, exp;
        int cycles;
        base = 24'hFFFFFE;
        bufferIn = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, base, '0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        cycles = 0;
        while (stall && cycles < 40) begin
            if (memRE) seen.push_back(memAddr);
            cycles++;
            tick();
        end
        checks++;
        if (cycles != 7) begin
            errors++; $display("FAIL vl_stall: stall cycles=%0d expected 7", cycles);
        end
        checks++;
        if (wbValid !== 1'b1 || wbRc !== 4'd9 || wbMemToReg !== 1'b1 || wbModeSel !== 1'b1) begin
            errors++; $display("FAIL vl_wb: valid=%b rc=%0d mtr=%b mode=%b expected 1 9 1 1",
                               wbValid, wbRc, wbMemToReg, wbModeSel);
        end
        checks++;
        if (seen.size() != 6) begin
            errors++; $display("FAIL vl_reads: read strobes=%0d expected 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp = base + N'(i);
                if (seen[i] !== exp) begin
                    errors++; $display("FAIL vl_addr%0d: got %h expected %h", i, seen[i], exp);
                    break;
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            exp = (base + N'(i)) ^ 24'h5A5A5A;
            checks++;
            if (wbReadData[i*N +: N] !== exp) begin
                errors++; $display("FAIL vl_data%0d: got %h expected %h", i, wbReadData[i*N +: N], exp);
            end
        end
        tick();
    endtask

    task automatic test_enable_hold();
        int cycles;
        wr_addr.delete(); wr_data.delete();
        bufferIn = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 24'h000200,
                      {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1});
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick(); tick();
        en = 1'b0;
        for (int h = 0; h < 3; h++) begin
            #1;
            checks++;
            if (memWE !== 1'b0 || memAddr !== 24'h000202 || stall !== 1'b1) begin
                errors++; $display("FAIL eh_hold%0d: we=%b addr=%h stall=%b expected 0 000202 1",
                                   h, memWE, memAddr, stall);
            end
            tick();
        end
        en = 1'b1;
        cycles = 0;
        while (stall && cycles < 40) begin
            cycles++;
            tick();
        end
        checks++;
        if (wbValid !== 1'b1 || cycles != 4) begin
            errors++; $display("FAIL eh_done: wbValid=%b remaining=%0d expected 1 4", wbValid, cycles);
        end
        checks++;
        if (wr_addr.size() != 6) begin
            errors++; $display("FAIL eh_count: writes=%0d expected 6", wr_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_addr[i] !== 24'h000200 + N'(i) || wr_data[i] !== N'(i + 1)) begin
                    errors++; $display("FAIL eh_write%0d: addr=%h data=%0d expected %h %0d",
                                       i, wr_addr[i], wr_data[i], 24'h000200 + N'(i), i + 1);
                    break;
                end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int at[2];
        logic [3:0] rcs[2];
        bufferIn = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 24'h000010, '0);
        inValid = 1'b1;
        tick();
        bufferIn = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 24'h000777, '0);
        pulses = 0;
        for (int cyc = 0; cyc < 20 && pulses < 2; cyc++) begin
            tick();
            if (wbValid) begin
                at[pulses] = cyc;
                rcs[pulses] = wbRc;
                if (pulses == 0) begin
                    checks++;
                    if (wbReadData[N-1:0] !== 24'h5A5A4A) begin
                        errors++; $display("FAIL b2b_load: got %h expected 5a5a4a", wbReadData[N-1:0]);
                    end
                end else begin
                    checks++;
                    if (wbAluResult !== 144'h777 || wbReadData !== '0) begin
                        errors++; $display("FAIL b2b_pt: alu=%h rd=%h expected 777 0", wbAluResult, wbReadData);
                    end
                end
                pulses++;
            end
        end
        inValid = 1'b0;
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end else begin
            checks++;
            if (rcs[0] !== 4'd3 || rcs[1] !== 4'd7 || at[0] != 1 || at[1] != 2) begin
                errors++; $display("FAIL b2b_order: rc=%0d,%0d cycle=%0d,%0d expected 3,7 1,2",
                                   rcs[0], rcs[1], at[0], at[1]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int logged;
        bufferIn = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 24'h000300,
                      {24'h66, 24'h55, 24'h44, 24'h33, 24'h22, 24'h11});
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (memWE !== 1'b1 || memAddr !== 24'h000303) begin
            errors++; $display("FAIL rs_lane3: we=%b addr=%h expected 1 000303", memWE, memAddr);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (memWE !== 1'b0 || stall !== 1'b0 || memRE !== 1'b0) begin
            errors++; $display("FAIL rs_async: we=%b stall=%b re=%b expected 0 0 0", memWE, stall, memRE);
        end
        checks++;
        if ({wbValid, wbModeSel, wbRegWrite, wbMemToReg, wbRc, wbAluResult, wbReadData,
             memAddr, memWData} !== '0) begin
            errors++; $display("FAIL rs_outputs: rc=%0d alu=%h addr=%h wdata=%h expected all 0",
                               wbRc, wbAluResult, memAddr, memWData);
        end
        logged = wr_addr.size();
        tick();
        #2 rst = 1'b1;
        repeat (10) tick();
        checks++;
        if (wr_addr.size() != logged || stall !== 1'b0 || wbValid !== 1'b0) begin
            errors++; $display("FAIL rs_after: extra writes=%0d stall=%b wbValid=%b expected 0 0 0",
                               wr_addr.size() - logged, stall, wbValid);
        end
    endtask

    task automatic test_exclusive_strobes();
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL excl: cycles with memWE and memRE both high=%0d expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_scalar_store();
        test_vector_load_wrap();
        test_enable_hold();
        test_back_to_back();
        test_reset_mid_store();
        test_exclusive_strobes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
